// File: rtl/div_ctrl_pkg.sv
// Shared types and default constants for the div_ctrl clock divider.
package div_ctrl_pkg;

    localparam int DEF_WIDTH   = 28;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_DIVISOR = 1000000;
    localparam int DEF_MIN_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

endpackage

// File: rtl/div_core.sv
// div_core: period counter plus registered q/tick generation.
// While run is low the counter is parked at 0 and q/tick are held low.
module div_core
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] div_act,
    output logic             q,
    output logic             tick,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;

    assign half = div_act >> 1;
    assign last = div_act - WIDTH'(1);

    // >= rather than == so an out-of-range count can never run away.
    assign wrap = run && (cnt_q >= last);

    // Next counter value and the registered q/tick derived from the current count.
    always_comb begin
        cnt_d  = '0;
        q_d    = 1'b0;
        tick_d = 1'b0;
        if (run) begin
            cnt_d  = wrap ? '0 : cnt_q + WIDTH'(1);
            q_d    = (cnt_q < half);
            tick_d = wrap;
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            q_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            tick_q <= tick_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: programmable clock divider with run/stop sequencing, a
// valid/ready config port and a one-deep shadow for glitch-free retuning.
// Optional build macro: DIV_CTRL_BURST_EN adds a period counter so a
// nonzero cfg_count ends the run after that many periods.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | outputs parked, config applied directly, shadow discarded
// ST_RUN      | dividing; config goes to shadow, loaded at the next wrap
// ST_STOPPING | stop seen, finishing the current period, config blocked
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIVISOR = DEF_DIVISOR,
    parameter int MIN_DIV = DEF_MIN_DIV
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             q,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] shd_div_q, shd_div_d;
    logic             shd_full_q, shd_full_d;
    logic             done_q, done_d;

    logic             run;
    logic             wrap;
    logic             cfg_xfer;
    logic [WIDTH-1:0] cfg_div_clamped;
    logic             burst_last;

`ifdef DIV_CTRL_BURST_EN
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shd_cnt_q, shd_cnt_d;
    logic [CNT_W-1:0] per_q, per_d;

    // per_q counts completed periods of the current run (or since the last
    // shadow load); the wrap that completes period count_q ends the run.
    assign burst_last = (count_q != '0) && (per_q == count_q - CNT_W'(1));
`else
    logic unused_cfg_count;

    assign unused_cfg_count = ^cfg_count;
    assign burst_last       = 1'b0;
`endif

    assign run             = (state_q != ST_IDLE);
    assign busy            = run;
    assign done            = done_q;
    assign cfg_ready       = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !shd_full_q);
    assign cfg_xfer        = cfg_valid && cfg_ready;
    assign cfg_div_clamped = (cfg_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : cfg_div;

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .div_act (div_act_q),
        .q       (q),
        .tick    (tick),
        .wrap    (wrap)
    );

    // Next-state, config handshake and shadow management.
    always_comb begin
        state_d    = state_q;
        div_act_d  = div_act_q;
        shd_div_d  = shd_div_q;
        shd_full_d = shd_full_q;
        done_d     = 1'b0;
`ifdef DIV_CTRL_BURST_EN
        count_d    = count_q;
        shd_cnt_d  = shd_cnt_q;
        per_d      = per_q;
`endif

        case (state_q)
            ST_IDLE: begin
                shd_full_d = 1'b0;
                if (cfg_xfer) begin
                    div_act_d = cfg_div_clamped;
`ifdef DIV_CTRL_BURST_EN
                    count_d   = cfg_count;
`endif
                end
                // start wins over a simultaneous stop
                if (start) begin
                    state_d = ST_RUN;
`ifdef DIV_CTRL_BURST_EN
                    per_d   = '0;
`endif
                end
            end

            ST_RUN: begin
                if (cfg_xfer) begin
                    shd_div_d  = cfg_div_clamped;
                    shd_full_d = 1'b1;
`ifdef DIV_CTRL_BURST_EN
                    shd_cnt_d  = cfg_count;
`endif
                end
                if (wrap) begin
                    if (stop || burst_last) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        shd_full_d = 1'b0;
                    end else if (shd_full_q) begin
                        // cfg_ready is low here, so no transfer can collide
                        div_act_d  = shd_div_q;
                        shd_full_d = 1'b0;
`ifdef DIV_CTRL_BURST_EN
                        count_d    = shd_cnt_q;
                        per_d      = '0;
`endif
                    end else begin
`ifdef DIV_CTRL_BURST_EN
                        per_d      = per_q + CNT_W'(1);
`endif
                    end
                end else if (stop) begin
                    state_d = ST_STOPPING;
                end
            end

            ST_STOPPING: begin
                if (wrap) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    shd_full_d = 1'b0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                shd_full_d = 1'b0;
            end
        endcase
    end

    // Control registers; reset aborts a run silently and restores DIVISOR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_act_q  <= WIDTH'(DIVISOR);
            shd_div_q  <= '0;
            shd_full_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_act_q  <= div_act_d;
            shd_div_q  <= shd_div_d;
            shd_full_q <= shd_full_d;
            done_q     <= done_d;
        end
    end

`ifdef DIV_CTRL_BURST_EN
    // Burst length, its shadow and the period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            shd_cnt_q <= '0;
            per_q     <= '0;
        end else begin
            count_q   <= count_d;
            shd_cnt_q <= shd_cnt_d;
            per_q     <= per_d;
        end
    end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl. Inputs change on the falling edge, outputs
// are observed on the falling edge (half a cycle after the active edge).
module tb_div_ctrl;

    localparam int WIDTH   = 28;
    localparam int CNT_W   = 16;
    localparam int DIVISOR = 5;
    localparam int MIN_DIV = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_count;
    logic             q;
    logic             tick;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    div_ctrl #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .DIVISOR (DIVISOR),
        .MIN_DIV (MIN_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_count (cfg_count),
        .q         (q),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer a config together with start from IDLE; returns just after the entry edge.
    task automatic go(input int div, input int cnt);
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(div);
        cfg_count = CNT_W'(cnt);
        start     = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("go_busy", busy, 1);
        check("go_q0", q, 0);
    endtask

    // n cycles of steady running; c0 is the counter value at the first edge.
    task automatic check_period(input string tag, input int div, input int n, input int c0);
        int c;
        for (int i = 0; i < n; i++) begin
            step();
            c = (c0 + i) % div;
            check({tag, "_q"}, q, (c < div / 2) ? 1 : 0);
            check({tag, "_tick"}, tick, (c == div - 1) ? 1 : 0);
            check({tag, "_busy"}, busy, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        stop = 1'b1;
        while (done !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        stop = 1'b0;
        check("drain_done", done, 1);
        step();
        check("drain_idle", busy, 0);
        check("drain_done_clr", done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int ticks;
        int c;

        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_count = '0;
        step();
        step();
        check("rst_q", q, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        reset = 1'b0;
        step();
        check("idle_ready", cfg_ready, 1);

        // div 4: q 1,1,0,0 with tick on the fourth cycle
        go(4, 0);
        check("run_ready", cfg_ready, 1);
        check_period("div4", 4, 8, 0);
        drain();

        // divisor 1 clamps to 2: q toggles each cycle
        go(1, 0);
        check_period("clamp", 2, 6, 0);
        drain();

        // retune 10 -> 6 mid-period through the shadow
        go(10, 0);
        check_period("sh10a", 10, 3, 0);
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(6);
        step();
        cfg_valid = 1'b0;
        check("sh_ready_drop", cfg_ready, 0);
        check("sh_q_c3", q, 1);
        for (int k = 4; k <= 9; k++) begin
            step();
            check("sh10b_q", q, (k < 5) ? 1 : 0);
            check("sh10b_tick", tick, (k == 9) ? 1 : 0);
            check("sh10b_ready", cfg_ready, (k == 9) ? 1 : 0);
        end
        check_period("sh6", 6, 12, 0);
        drain();

        // stop at counter 3, div 8: period completes, single done
        go(8, 0);
        check_period("stp8", 8, 3, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stp_busy", busy, 1);
        check("stp_ready", cfg_ready, 0);
        check("stp_q_c3", q, 1);
        check("stp_done_early", done, 0);
        dones = 0;
        for (c = 4; c <= 7; c++) begin
            step();
            check("stp_q", q, (c < 4) ? 1 : 0);
            check("stp_tick", tick, (c == 7) ? 1 : 0);
            check("stp_busy_run", busy, (c == 7) ? 0 : 1);
            if (done === 1'b1) dones++;
        end
        step();
        if (done === 1'b1) dones++;
        check("stp_after_q", q, 0);
        check("stp_after_busy", busy, 0);
        check("stp_done_count", dones, 1);

        // stop coincident with the wrap: straight to IDLE
        go(4, 0);
        check_period("stpw", 4, 3, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stpw_busy", busy, 0);
        check("stpw_done", done, 1);
        check("stpw_tick", tick, 1);
        step();
        check("stpw_done_clr", done, 0);
        check("stpw_q", q, 0);

        // start and stop together in IDLE: start wins
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(4);
        start     = 1'b1;
        stop      = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        check("ss_busy", busy, 1);
        check_period("ss", 4, 4, 0);
        drain();

        // cfg_count = 3 with div 4
        go(4, 3);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick === 1'b1) ticks++;
            if (done === 1'b1) dones++;
        end
`ifdef DIV_CTRL_BURST_EN
        check("burst_ticks", ticks, 3);
        check("burst_dones", dones, 1);
        check("burst_busy", busy, 0);
`else
        check("cont_ticks", ticks, 5);
        check("cont_dones", dones, 0);
        check("cont_busy", busy, 1);
        drain();
`endif

        // asynchronous reset mid-run, then restart on the reset divisor
        go(4, 0);
        check_period("ar", 4, 2, 0);
        #2 reset = 1'b1;
        #1;
        check("ar_q", q, 0);
        check("ar_busy", busy, 0);
        check("ar_tick", tick, 0);
        check("ar_done", done, 0);
        check("ar_ready", cfg_ready, 1);
        step();
        check("ar_hold_done", done, 0);
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ar_restart_busy", busy, 1);
        check("ar_restart_done", done, 0);
        check_period("ardef", DIVISOR, 10, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 28, divisor/counter width.
REQ-002 SHALL have parameter CNT_W, default 16, burst period-count width.
REQ-003 SHALL have parameter DIVISOR, default 1000000, active divisor after reset.
REQ-004 SHALL have parameter MIN_DIV, default 2, smallest legal divisor.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level sampled per cycle, begin output generation.
REQ-008 SHALL have port stop  input  1  level sampled per cycle, end after the current period.
REQ-009 SHALL have port cfg_valid  input  1  config offer.
REQ-010 SHALL have port cfg_ready  output  1  config accept.
REQ-011 SHALL have port cfg_div  input  WIDTH  requested divisor.
REQ-012 SHALL have port cfg_count  input  CNT_W  periods per run, 0 = continuous.
REQ-013 SHALL have port q  output  1  divided clock, registered.
REQ-014 SHALL have port tick  output  1  one-cycle pulse on the last cycle of each period.
REQ-015 SHALL have port busy  output  1  high in RUN or STOPPING.
REQ-016 SHALL have port done  output  1  one-cycle pulse on the return to IDLE.

Function
REQ-017 SHALL implement states IDLE, RUN, STOPPING.
REQ-018 In RUN and STOPPING, counter SHALL step 0..div_act-1 and then wrap to 0.
REQ-019 q SHALL be registered as (counter < div_act/2), integer divide; period = div_act cycles, high time = floor(div_act/2).
REQ-020 tick SHALL be 1 in the cycle after the counter equals div_act-1, same registered alignment as q.
REQ-021 A transfer SHALL occur when cfg_valid and cfg_ready are both 1; cfg_div below MIN_DIV SHALL be clamped to MIN_DIV.
REQ-022 In IDLE, cfg_ready SHALL be 1 and an accepted config SHALL take effect immediately.
REQ-023 In RUN, an accepted config SHALL go to a shadow register and cfg_ready SHALL be 0 while the shadow is full.
REQ-024 The shadow SHALL load into div_act/count at the next counter wrap; the new period starts at counter 0.
REQ-025 In STOPPING, cfg_ready SHALL be 0.
REQ-026 IDLE->RUN SHALL occur on start; counter=0 and periods=0 on entry; the first q high appears the next cycle.
REQ-027 start in RUN or STOPPING SHALL be ignored.
REQ-028 stop in RUN SHALL cause RUN->STOPPING; at the next wrap, STOPPING->IDLE with done=1.
REQ-029 stop coincident with a wrap in RUN SHALL go directly to IDLE with done=1.
REQ-030 start and stop together in IDLE: start SHALL win and stop SHALL be ignored.
REQ-031 In IDLE, q SHALL be held 0 and the counter held 0; a pending shadow SHALL be discarded.

Reset
REQ-032 On reset assertion, outputs SHALL go immediately to q=0, tick=0, busy=0, done=0, cfg_ready=1.
REQ-033 On reset, state SHALL be IDLE, div_act=DIVISOR, count=0, shadow empty.
REQ-034 Reset mid-run SHALL abort without a done pulse.

Configuration
REQ-035 Macro DIV_CTRL_BURST_EN defined: a nonzero cfg_count SHALL end RUN after exactly cfg_count periods (IDLE, done=1 on the final wrap); a period counter of CNT_W bits SHALL be present.
REQ-036 Macro DIV_CTRL_BURST_EN undefined: cfg_count SHALL be ignored, operation SHALL be continuous until stop, and no period counter SHALL exist.

Structure
REQ-037 Package div_ctrl_pkg SHALL hold the state enum type and the default constants (WIDTH, DIVISOR, MIN_DIV).
REQ-038 The counter/q/tick datapath SHALL be sub-module div_core (inputs run, div_act; outputs q, tick, wrap); div_ctrl holds the FSM, handshake and shadow.

Verification
REQ-039 Reset, cfg_div=4, start: q SHALL be 1,1,0,0 repeating; tick every 4th cycle; busy=1.
REQ-040 cfg_div=1 accepted: SHALL be clamped to 2; q SHALL toggle every cycle.
REQ-041 Running div=10, cfg_div=6 mid-period: cfg_ready SHALL drop; the current 10-cycle period SHALL complete, then 6-cycle periods follow and cfg_ready=1.
REQ-042 stop at counter=3, div=8: q SHALL complete the period; done SHALL pulse once; busy=0 after the wrap; stop at the wrap cycle SHALL give immediate IDLE.
REQ-043 DIV_CTRL_BURST_EN, cfg_count=3, div=4: exactly 3 tick pulses then done; with the macro undefined, periods continue until stop.
REQ-044 Reset asserted mid-RUN: q and busy SHALL go 0 asynchronously; no done pulse; div_act SHALL return to DIVISOR.
